// File: rtl/piano_pkg.sv
// Shared sizing constants and types for the polyphonic tone generator.
package piano_pkg;

   localparam int unsigned NUM_VOICES = 13;
   localparam int unsigned PERIOD_W   = 32;
   localparam int unsigned MIX_W      = 4;
   localparam int unsigned CLK_HZ     = 50_000_000;

   typedef logic [PERIOD_W-1:0] period_t;
   typedef logic [MIX_W-1:0]    mix_t;

   typedef enum logic {
      V_IDLE,
      V_RUN
   } voice_state_t;

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: latches its half-period at note-on and at every
// wave edge, so period changes never truncate a half-cycle.
module tone_voice #(
   parameter int unsigned PERIOD_W = piano_pkg::PERIOD_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] half_period,
   output logic                wave,
   output logic                active
);
   import piano_pkg::*;

   voice_state_t        r_state;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] r_per_q;
   logic                r_wave;
   logic                r_active;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= V_IDLE;
         r_cnt    <= '0;
         r_per_q  <= '0;
         r_wave   <= 1'b0;
         r_active <= 1'b0;
      end else begin
         case (r_state)
            V_IDLE: begin
               if (enable && (half_period != '0)) begin
                  r_state  <= V_RUN;
                  r_per_q  <= half_period;
                  r_cnt    <= '0;
                  r_wave   <= 1'b0;
                  r_active <= 1'b1;
               end
            end
            V_RUN: begin
               // Stop wins over the boundary: mute is immediate, no phase completion.
               if (!enable || (half_period == '0)) begin
                  r_state  <= V_IDLE;
                  r_cnt    <= '0;
                  r_per_q  <= '0;
                  r_wave   <= 1'b0;
                  r_active <= 1'b0;
               end else if (r_cnt == r_per_q - 1'b1) begin
                  r_cnt   <= '0;
                  r_wave  <= ~r_wave;
                  r_per_q <= half_period;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= V_IDLE;
         endcase
      end
   end

   assign wave   = r_wave;
   assign active = r_active;

endmodule

// File: rtl/note_synth.sv
// Polyphonic square-wave synth: NUM_VOICES tone voices summed into a
// registered mix, then first-order sigma-delta modulated onto one PDM pin.
module note_synth #(
   parameter int unsigned NUM_VOICES = piano_pkg::NUM_VOICES,
   parameter int unsigned PERIOD_W   = piano_pkg::PERIOD_W,
   parameter int unsigned MIX_W      = piano_pkg::MIX_W
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [NUM_VOICES-1:0][PERIOD_W-1:0] half_period,
   output logic [NUM_VOICES-1:0]               voice_wave,
   output logic [NUM_VOICES-1:0]               voice_active,
   output logic [MIX_W-1:0]                    mix,
   output logic                                audio_pdm
);
   import piano_pkg::*;

   localparam logic [MIX_W:0] NV_W = (MIX_W+1)'(NUM_VOICES);

   logic [MIX_W-1:0] w_pop;
   logic [MIX_W:0]   w_sum;
   logic [MIX_W-1:0] r_mix;
   logic [MIX_W:0]   r_acc;
   logic             r_pdm;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      tone_voice #(.PERIOD_W(PERIOD_W)) u_voice (
         .clk        (clk),
         .reset      (reset),
         .enable     (enable),
         .half_period(half_period[g]),
         .wave       (voice_wave[g]),
         .active     (voice_active[g])
      );
   end

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         w_pop = w_pop + MIX_W'(voice_wave[i]);
      end
      w_sum = r_acc + {1'b0, r_mix};
   end

   // acc stays below NUM_VOICES, so acc+mix always fits in MIX_W+1 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mix <= '0;
         r_acc <= '0;
         r_pdm <= 1'b0;
      end else begin
         r_mix <= w_pop;
         if (w_sum >= NV_W) begin
            r_pdm <= 1'b1;
            r_acc <= w_sum - NV_W;
         end else begin
            r_pdm <= 1'b0;
            r_acc <= w_sum;
         end
      end
   end

   assign mix       = r_mix;
   assign audio_pdm = r_pdm;

endmodule

// File: tb/tb_note_synth.sv
// Self-checking bench for note_synth: directed scenarios plus randomized
// traffic against a countdown-based behavioural model of the voices and mixer.
module tb_note_synth;
   localparam int NV = 13;
   localparam int PW = 32;
   localparam int MW = 4;
   localparam int VW = 2*NV + MW + 1;

   logic                   clk;
   logic                   reset;
   logic                   enable;
   logic [NV-1:0][PW-1:0]  half_period;
   logic [NV-1:0]          voice_wave;
   logic [NV-1:0]          voice_active;
   logic [MW-1:0]          mix;
   logic                   audio_pdm;

   int checks;
   int failures;

   // Model: each running voice counts down the cycles left in its half-cycle.
   int unsigned m_rem [NV];
   bit          m_lvl [NV];
   bit          m_act [NV];
   int          m_mix;
   int          m_acc;
   bit          m_pdm;

   note_synth #(.NUM_VOICES(NV), .PERIOD_W(PW), .MIX_W(MW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .half_period (half_period),
      .voice_wave  (voice_wave),
      .voice_active(voice_active),
      .mix         (mix),
      .audio_pdm   (audio_pdm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] exp_vec();
      logic [NV-1:0] w;
      logic [NV-1:0] a;
      for (int i = 0; i < NV; i++) begin
         w[i] = m_lvl[i];
         a[i] = m_act[i];
      end
      return {w, a, MW'(m_mix), m_pdm};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {voice_wave, voice_active, mix, audio_pdm};
   endfunction

   task automatic tick();
      int pop;
      @(posedge clk);
      pop = 0;
      for (int i = 0; i < NV; i++) pop += int'(m_lvl[i]);
      if (reset) begin
         for (int i = 0; i < NV; i++) begin
            m_rem[i] = 0; m_lvl[i] = 0; m_act[i] = 0;
         end
         m_mix = 0; m_acc = 0; m_pdm = 0;
      end else begin
         if (m_acc + m_mix >= NV) begin
            m_pdm = 1; m_acc = m_acc + m_mix - NV;
         end else begin
            m_pdm = 0; m_acc = m_acc + m_mix;
         end
         m_mix = pop;
         for (int i = 0; i < NV; i++) begin
            if (!m_act[i]) begin
               if (enable && half_period[i] != 0) begin
                  m_act[i] = 1; m_lvl[i] = 0; m_rem[i] = half_period[i];
               end
            end else if (!enable || half_period[i] == 0) begin
               m_act[i] = 0; m_lvl[i] = 0; m_rem[i] = 0;
            end else begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_lvl[i] = ~m_lvl[i];
                  m_rem[i] = half_period[i];
               end
            end
         end
      end
      #1;
   endtask

   task automatic clean_start();
      reset = 1'b1; enable = 1'b0; half_period = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; half_period = '0;
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (dut_vec() !== '0) begin
         failures++;
         $display("FAIL reset_hold got=%h want=0", dut_vec());
      end
      reset = 1'b0;
      for (int c = 0; c < 200; c++) begin
         tick();
         checks++;
         if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_idle cycle=%0d got=%h want=0", c, dut_vec());
         end
      end
   endtask

   task automatic test_single_voice();
      int since;
      logic prev;
      clean_start();
      enable = 1'b1;
      half_period[0] = 32'd4;
      tick();
      checks++;
      if (voice_active[0] !== 1'b1 || voice_wave[0] !== 1'b0) begin
         failures++;
         $display("FAIL single_start got act=%b wave=%b want act=1 wave=0",
                  voice_active[0], voice_wave[0]);
      end
      since = 0;
      prev = voice_wave[0];
      for (int c = 0; c < 80; c++) begin
         tick();
         since++;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL single_model cycle=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
         if (voice_wave[0] !== prev) begin
            checks++;
            if (since != 4) begin
               failures++;
               $display("FAIL single_halfcycle got=%0d want=4", since);
            end
            since = 0;
            prev = voice_wave[0];
         end
      end
   endtask

   task automatic test_period_change();
      int n;
      int want [3];
      logic prev;
      want[0] = 8; want[1] = 3; want[2] = 3;
      clean_start();
      enable = 1'b1;
      half_period[3] = 32'd10;
      tick();
      tick();
      tick();
      half_period[3] = 32'd3;
      for (int k = 0; k < 3; k++) begin
         prev = voice_wave[3];
         n = 0;
         while (voice_wave[3] === prev && n < 20) begin
            tick();
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL change_model got=%h want=%h", dut_vec(), exp_vec());
            end
         end
         checks++;
         if (n != want[k]) begin
            failures++;
            $display("FAIL change_halfcycle idx=%0d got=%0d want=%0d", k, n, want[k]);
         end
      end
   endtask

   task automatic test_all_voices();
      logic [MW-1:0] prev_mix;
      bit seen_full;
      clean_start();
      enable = 1'b1;
      for (int i = 0; i < NV; i++) half_period[i] = 32'd2;
      seen_full = 0;
      for (int c = 0; c < 40; c++) begin
         prev_mix = mix;
         tick();
         checks++;
         if (voice_wave !== '0 && voice_wave !== '1) begin
            failures++;
            $display("FAIL all_in_phase got=%b want=all-equal", voice_wave);
         end
         if (prev_mix == MW'(NV)) begin
            seen_full = 1;
            checks++;
            if (audio_pdm !== 1'b1) begin
               failures++;
               $display("FAIL all_pdm_full got=%b want=1", audio_pdm);
            end
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL all_model cycle=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
      checks++;
      if (!seen_full) begin
         failures++;
         $display("FAIL all_mix_full got=no-13 want=mix reaches 13");
      end
   endtask

   task automatic test_enable_drop();
      int n;
      clean_start();
      enable = 1'b1;
      half_period[5] = 32'd3;
      n = 0;
      while (voice_wave[5] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (voice_wave[5] !== 1'b1) begin
         failures++;
         $display("FAIL drop_timeout got wave=%b want=1 within 20 cycles", voice_wave[5]);
      end
      enable = 1'b0;
      tick();
      checks++;
      if (voice_wave[5] !== 1'b0 || voice_active[5] !== 1'b0) begin
         failures++;
         $display("FAIL drop_mute got wave=%b act=%b want 0 0", voice_wave[5], voice_active[5]);
      end
      enable = 1'b1;
      tick();
      checks++;
      if (voice_wave[5] !== 1'b0 || voice_active[5] !== 1'b1) begin
         failures++;
         $display("FAIL drop_restart got wave=%b act=%b want 0 1", voice_wave[5], voice_active[5]);
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL drop_model cycle=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      int run;
      clean_start();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) half_period[i*2] = 32'($urandom_range(9, 1));
      run = int'($urandom_range(40, 10));
      for (int c = 0; c < run; c++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL midreset_pre got=%h want=%h", dut_vec(), exp_vec());
         end
      end
      reset = 1'b1;
      tick();
      checks++;
      if (dut_vec() !== '0) begin
         failures++;
         $display("FAIL midreset_clear got=%h want=0", dut_vec());
      end
      reset = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL midreset_post cycle=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      clean_start();
      enable = 1'b1;
      for (int i = 0; i < NV; i++) half_period[i] = 32'($urandom_range(12, 0));
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(19, 0) == 0)
            half_period[$urandom_range(NV-1, 0)] = 32'($urandom_range(12, 0));
         enable = ($urandom_range(149, 0) != 0);
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random_model cycle=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      enable = 1'b0;
      half_period = '0;
      for (int i = 0; i < NV; i++) begin
         m_rem[i] = 0; m_lvl[i] = 0; m_act[i] = 0;
      end
      m_mix = 0; m_acc = 0; m_pdm = 0;
      @(negedge clk);
      test_reset();
      test_single_voice();
      test_period_change();
      test_all_voices();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
